// File: rtl/extend_acc.sv
// extend_acc: block accumulator for narrow samples.
// Each sample is widened (sign- or zero-extended), summed over a block of
// acc_len+1 samples, and the total is saturated to BW_OUT bits. The result
// stays in a HOLD state until the consumer accepts it.
module extend_acc #(
   parameter int BW_IN  = 3,
   parameter int BW_OUT = 4,
   parameter int NUM_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              data_in_is_signed,
   input  logic [NUM_W-1:0]  acc_len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BW_IN-1:0]  data_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BW_OUT-1:0] data_out,
   output logic              out_overflow
);

   // The accumulator is wide enough that 2^NUM_W samples of either sign
   // can never wrap it.
   localparam int ACC_W = BW_IN + NUM_W + 1;
   // Comparison width: one bit wider than both the sum and the output, so
   // the clamp limits and the widened sum are all representable as signed.
   localparam int SAT_W = ((ACC_W > BW_OUT) ? ACC_W : BW_OUT) + 1;

   localparam logic signed [SAT_W-1:0] S_MAX = SAT_W'((2 ** (BW_OUT - 1)) - 1);
   localparam logic signed [SAT_W-1:0] S_MIN = ~S_MAX;
   localparam logic signed [SAT_W-1:0] U_MAX = SAT_W'((2 ** BW_OUT) - 1);

   typedef enum logic {
      ACC,
      HOLD
   } state_t;

   state_t state, state_next;

   logic [ACC_W-1:0]        acc;
   logic [ACC_W-1:0]        acc_next;
   logic [ACC_W-1:0]        sample_ext;
   logic [NUM_W-1:0]        cnt;
   logic [NUM_W-1:0]        len_q;
   logic [NUM_W-1:0]        len_eff;
   logic                    mode_q;
   logic                    mode_eff;
   logic                    first_beat;
   logic                    beat;
   logic                    last_beat;
   logic signed [SAT_W-1:0] sum_ext;
   logic [BW_OUT-1:0]       sat_val;
   logic                    sat_ovf;

   // A beat depends only on the state, never on the FSM's own outputs.
   assign beat       = in_valid && (state == ACC);
   assign first_beat = (cnt == '0);
   assign last_beat  = beat && (cnt == len_eff);

   // Widen the incoming sample, form the running sum and saturate it.
   // On the first beat the live mode/length are used, since they are
   // being latched on that same edge.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      mode_eff   = first_beat ? data_in_is_signed : mode_q;
      len_eff    = first_beat ? acc_len : len_q;
      sample_ext = {{(ACC_W - BW_IN){data_in[BW_IN-1] & mode_eff}}, data_in};
      acc_next   = acc + sample_ext;
      sum_ext    = {{(SAT_W - ACC_W){acc_next[ACC_W-1] & mode_eff}}, acc_next};
      sat_val    = sum_ext[BW_OUT-1:0];
      sat_ovf    = 1'b0;
      if (mode_eff) begin
         if (sum_ext > S_MAX) begin
            sat_val = S_MAX[BW_OUT-1:0];
            sat_ovf = 1'b1;
         end else if (sum_ext < S_MIN) begin
            sat_val = S_MIN[BW_OUT-1:0];
            sat_ovf = 1'b1;
         end
      end else if (sum_ext > U_MAX) begin
         sat_val = U_MAX[BW_OUT-1:0];
         sat_ovf = 1'b1;
      end
   end

   // State register; reset wins over any handshake on the same edge.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         state <= ACC;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         ACC: begin
            in_ready = 1'b1;
            if (last_beat) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = ACC;
            end
         end
         default: state_next = ACC;
      endcase
   end

   // Accumulator, beat counter, latched block settings and result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc          <= '0;
         cnt          <= '0;
         mode_q       <= 1'b0;
         len_q        <= '0;
         data_out     <= '0;
         out_overflow <= 1'b0;
      end else if (beat) begin
         if (first_beat) begin
            mode_q <= data_in_is_signed;
            len_q  <= acc_len;
         end
         acc <= acc_next;
         if (last_beat) begin
            data_out     <= sat_val;
            out_overflow <= sat_ovf;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else if ((state == HOLD) && out_ready) begin
         acc <= '0;
         cnt <= '0;
      end
   end

endmodule

// File: tb/tb_extend_acc.sv
// tb_extend_acc: scoreboard bench for extend_acc. Expected block results are
// computed by an integer model when a block is driven and compared when the
// DUT hands the result over.
module tb_extend_acc;

   localparam int BW_IN  = 3;
   localparam int BW_OUT = 4;
   localparam int NUM_W  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              data_in_is_signed;
   logic [NUM_W-1:0]  acc_len;
   logic              in_valid;
   logic              in_ready;
   logic [BW_IN-1:0]  data_in;
   logic              out_valid;
   logic              out_ready;
   logic [BW_OUT-1:0] data_out;
   logic              out_overflow;

   typedef struct {
      int data;
      int ovf;
   } res_t;

   res_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   extend_acc #(
      .BW_IN (BW_IN),
      .BW_OUT(BW_OUT),
      .NUM_W (NUM_W)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .data_in_is_signed(data_in_is_signed),
      .acc_len          (acc_len),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .data_in          (data_in),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .data_out         (data_out),
      .out_overflow     (out_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference: integer sum of the widened samples, clamped to the output range.
   function automatic res_t model(input bit sgn, input int n,
                                  input int v0, input int v1, input int v2, input int v3);
      int   vals[4];
      int   sum;
      int   raw;
      int   lo;
      int   hi;
      res_t r;
      vals = '{v0, v1, v2, v3};
      sum  = 0;
      for (int i = 0; i < n; i++) begin
         raw = vals[i] & ((1 << BW_IN) - 1);
         if (sgn && raw >= (1 << (BW_IN - 1))) raw -= (1 << BW_IN);
         sum += raw;
      end
      if (sgn) begin
         lo = -(1 << (BW_OUT - 1));
         hi = (1 << (BW_OUT - 1)) - 1;
      end else begin
         lo = 0;
         hi = (1 << BW_OUT) - 1;
      end
      r.ovf = (sum > hi || sum < lo) ? 1 : 0;
      if (sum > hi) sum = hi;
      if (sum < lo) sum = lo;
      r.data = sum & ((1 << BW_OUT) - 1);
      return r;
   endfunction

   // Result monitor: pops the scoreboard on every output handshake.
   always @(negedge clk) begin
      res_t e;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("data_out", 32'(data_out), 32'(e.data));
            check("out_overflow", 32'(out_overflow), 32'(e.ovf));
         end
      end
   end

   // Present one sample on the first negedge where the block is ready;
   // the beat happens on the following posedge.
   task automatic drive_beat(input int v, input bit sgn, input int len);
      int waited;
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
      data_in           = v[BW_IN-1:0];
      data_in_is_signed = sgn;
      acc_len           = len[NUM_W-1:0];
      in_valid          = 1'b1;
      @(posedge clk);
   endtask

   // Drive one full block; mode/length after the first beat may differ to
   // show that only the first-beat values matter. Returns on the negedge
   // one cycle after the last beat.
   task automatic run_block(input bit sgn, input int len,
                            input int v0, input int v1, input int v2, input int v3,
                            input bit sgn_later, input int len_later);
      int vals[4];
      vals = '{v0, v1, v2, v3};
      sb.push_back(model(sgn, len + 1, v0, v1, v2, v3));
      for (int i = 0; i <= len; i++) begin
         drive_beat(vals[i], (i == 0) ? sgn : sgn_later, (i == 0) ? len : len_later);
      end
      @(negedge clk);
      check("latency_out_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst               = 1'b1;
      in_valid          = 1'b0;
      data_in           = '0;
      data_in_is_signed = 1'b0;
      acc_len           = '0;
      out_ready         = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_out_overflow", 32'(out_overflow), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Unsigned basic and saturating blocks.
      run_block(0, 3, 1, 2, 3, 4, 0, 3);
      run_block(0, 3, 7, 7, 7, 7, 0, 3);

      // Signed boundary sequence.
      run_block(1, 1, -4, -4, 0, 0, 1, 1);
      run_block(1, 2, -4, -4, -4, 0, 1, 2);
      run_block(1, 1, 3, 3, 0, 0, 1, 1);
      run_block(1, 2, 3, 3, 3, 0, 1, 2);

      // Single-sample blocks.
      run_block(1, 0, -3, 0, 0, 0, 1, 0);
      run_block(0, 0, 7, 0, 0, 0, 0, 0);
      run_block(1, 0, 3, 0, 0, 0, 1, 0);

      // Back-pressure: result held, inputs offered but not consumed.
      @(posedge clk);
      #1 out_ready = 1'b0;
      run_block(0, 1, 2, 3, 0, 0, 0, 1);
      in_valid = 1'b1;
      data_in  = 3'd7;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_out_valid", 32'(out_valid), 32'd1);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         check("hold_data_out", 32'(data_out), 32'(sb[0].data));
         check("hold_out_overflow", 32'(out_overflow), 32'(sb[0].ovf));
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      run_block(0, 1, 1, 1, 0, 0, 0, 1);

      // Reset in the middle of a block discards the partial sum.
      drive_beat(5, 0, 3);
      drive_beat(5, 0, 3);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_mid_in_ready", 32'(in_ready), 32'd1);
      check("rst_mid_out_valid", 32'(out_valid), 32'd0);
      check("rst_mid_data_out", 32'(data_out), 32'd0);
      rst = 1'b0;
      run_block(0, 3, 1, 1, 1, 1, 0, 3);

      // Reset while a result is pending drops that result.
      @(posedge clk);
      #1 out_ready = 1'b0;
      run_block(0, 0, 3, 0, 0, 0, 0, 0);
      rst = 1'b1;
      void'(sb.pop_back());
      @(posedge clk);
      @(negedge clk);
      check("rst_pend_out_valid", 32'(out_valid), 32'd0);
      check("rst_pend_data_out", 32'(data_out), 32'd0);
      check("rst_pend_out_overflow", 32'(out_overflow), 32'd0);
      rst       = 1'b0;
      out_ready = 1'b1;

      // Mode and length changed after the first beat are ignored.
      run_block(1, 1, 7, 7, 0, 0, 0, 3);
      run_block(0, 2, 6, 6, 6, 0, 1, 0);

      // A few random blocks.
      for (int k = 0; k < 8; k++) begin
         run_block(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end

      @(negedge clk);
      @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
